// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// ALUOp codes consumed by ALU_control, and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  // DECODE dispatch target for an opcode; anything unrecognised traps.
  function automatic state_e decode_target(input logic [6:0] op);
    state_e tgt;
    case (op)
      OP_LW, OP_SW: tgt = S_MEMADR;
      OP_R:         tgt = S_EXECR;
      OP_I:         tgt = S_EXECI;
      OP_JAL:       tgt = S_JAL;
      OP_BEQ:       tgt = S_BEQ;
      default:      tgt = S_ILLEGAL;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/imm_src_decode.sv
// Immediate-format select derived straight from the opcode field of IR.
module imm_src_decode (
  input  logic [6:0] op_i,
  output logic [1:0] imm_src_o
);
  import riscv_ctrl_pkg::*;

  // Opcode to immediate format; unknown opcodes fall back to I-format.
  always_comb begin
    imm_src_o = IMM_I;
    case (op_i)
      OP_LW, OP_I: imm_src_o = IMM_I;
      OP_SW:       imm_src_o = IMM_S;
      OP_BEQ:      imm_src_o = IMM_B;
      OP_JAL:      imm_src_o = IMM_J;
      default:     imm_src_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute,
// stalls on mem_ready and drives datapath selects and write enables.
module multicycle_control #(
  parameter int MEM_WAIT_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);
  import riscv_ctrl_pkg::*;

  localparam logic WAIT_EN = (MEM_WAIT_EN != 0);

  state_e     state_q, state_d;
  logic       ready_s;
  logic       branch_s, pc_update_s, irwrite_s, memwrite_s, regwrite_s;
  logic       done_s, illegal_s, adrsrc_s;
  logic [1:0] resultsrc_s, srca_s, srcb_s, aluop_s;

  assign ready_s = WAIT_EN ? mem_ready : 1'b1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode; unlisted outputs stay 0.
  always_comb begin
    state_d     = S_FETCH;
    branch_s    = 1'b0;
    pc_update_s = 1'b0;
    irwrite_s   = 1'b0;
    memwrite_s  = 1'b0;
    regwrite_s  = 1'b0;
    done_s      = 1'b0;
    illegal_s   = 1'b0;
    adrsrc_s    = ADR_PC;
    resultsrc_s = RES_ALUOUT;
    srca_s      = SRCA_PC;
    srcb_s      = SRCB_RS2;
    aluop_s     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        adrsrc_s    = ADR_PC;
        srca_s      = SRCA_PC;
        srcb_s      = SRCB_FOUR;
        aluop_s     = ALUOP_ADD;
        resultsrc_s = RES_ALURESULT;
        irwrite_s   = ready_s;
        pc_update_s = ready_s;
        if (ready_s) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // ALU precomputes OldPC + Imm so BEQ can reuse it from ALUOut.
        srca_s  = SRCA_OLDPC;
        srcb_s  = SRCB_IMM;
        aluop_s = ALUOP_ADD;
        state_d = decode_target(op);
      end
      S_MEMADR: begin
        srca_s  = SRCA_RS1;
        srcb_s  = SRCB_IMM;
        aluop_s = ALUOP_ADD;
        if (op == OP_LW) begin
          state_d = S_MEMREAD;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        resultsrc_s = RES_ALUOUT;
        adrsrc_s    = ADR_ALUOUT;
        if (ready_s) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        resultsrc_s = RES_DATA;
        regwrite_s  = 1'b1;
        done_s      = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        resultsrc_s = RES_ALUOUT;
        adrsrc_s    = ADR_ALUOUT;
        memwrite_s  = 1'b1;
        done_s      = ready_s;
        if (ready_s) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_EXECR: begin
        srca_s  = SRCA_RS1;
        srcb_s  = SRCB_RS2;
        aluop_s = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        resultsrc_s = RES_ALUOUT;
        regwrite_s  = 1'b1;
        done_s      = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXECI: begin
        srca_s  = SRCA_RS1;
        srcb_s  = SRCB_IMM;
        aluop_s = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_JAL: begin
        // Jump target sits in ALUOut; PC+4 computed now is written back in ALUWB.
        srca_s      = SRCA_OLDPC;
        srcb_s      = SRCB_FOUR;
        aluop_s     = ALUOP_ADD;
        resultsrc_s = RES_ALUOUT;
        pc_update_s = 1'b1;
        state_d     = S_ALUWB;
      end
      S_BEQ: begin
        srca_s      = SRCA_RS1;
        srcb_s      = SRCB_RS2;
        aluop_s     = ALUOP_SUB;
        resultsrc_s = RES_ALUOUT;
        branch_s    = 1'b1;
        done_s      = 1'b1;
        state_d     = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal_s = 1'b1;
        done_s    = 1'b1;
        state_d   = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Write enables and pulses are held off while reset is asserted.
  assign PCWrite    = rst_n & ((branch_s & Zero) | pc_update_s);
  assign IRWrite    = rst_n & irwrite_s;
  assign MemWrite   = rst_n & memwrite_s;
  assign RegWrite   = rst_n & regwrite_s;
  assign instr_done = rst_n & done_s;
  assign illegal_op = rst_n & illegal_s;
  assign AdrSrc     = adrsrc_s;
  assign ResultSrc  = resultsrc_s;
  assign ALUSrcA    = srca_s;
  assign ALUSrcB    = srcb_s;
  assign ALUOp      = aluop_s;
  assign state_dbg  = state_q;

  imm_src_decode u_imm_src_decode (
    .op_i      (op),
    .imm_src_o (ImmSrc)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed cases from the test plan
// followed by a random instruction stream checked against an instruction-level model.
module tb_multicycle_control;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [6:0] T_BEQ = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       Zero, mem_ready;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic       instr_done, illegal_op;
  logic [3:0] state_dbg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_WAIT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .instr_done(instr_done), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 lw, 1 sw, 2 R, 3 I, 4 jal, 5 beq, 6 illegal
  function automatic int kind_of(input logic [6:0] o);
    if (o == T_LW) return 0;
    if (o == T_SW) return 1;
    if (o == T_R) return 2;
    if (o == T_I) return 3;
    if (o == T_JAL) return 4;
    if (o == T_BEQ) return 5;
    return 6;
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    if (o == T_SW) return 2'b01;
    if (o == T_BEQ) return 2'b10;
    if (o == T_JAL) return 2'b11;
    return 2'b00;
  endfunction

  // Expected {PCWrite,AdrSrc,IRWrite,MemWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,instr_done,illegal_op}
  function automatic logic [14:0] exp_bundle(input int st, input logic rdy, input logic z);
    logic pcw, adr, irw, mw, rw, dn, il;
    logic [1:0] rs, sa, sb, ao;
    {pcw, adr, irw, mw, rw, dn, il} = 7'b0;
    {rs, sa, sb, ao} = 8'b0;
    case (st)
      0:  begin irw = rdy; pcw = rdy; sb = 2'b10; rs = 2'b10; end
      1:  begin sa = 2'b01; sb = 2'b01; end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  adr = 1'b1;
      4:  begin rs = 2'b01; rw = 1'b1; dn = 1'b1; end
      5:  begin adr = 1'b1; mw = 1'b1; dn = rdy; end
      6:  begin sa = 2'b10; ao = 2'b10; end
      7:  begin rw = 1'b1; dn = 1'b1; end
      8:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
      9:  begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
      10: begin sa = 2'b10; ao = 2'b01; pcw = z; dn = 1'b1; end
      11: begin il = 1'b1; dn = 1'b1; end
      default: ;
    endcase
    return {pcw, adr, irw, mw, rw, rs, sa, sb, ao, dn, il};
  endfunction

  // Runs one instruction from FETCH; fw/mw are memory wait cycles, bz is Zero in BEQ,
  // zmode sets Zero elsewhere (0 low, 1 high in DECODE only, 2 random).
  task automatic run_instr(input logic [6:0] o, input int fw, input int mw,
                           input logic bz, input int zmode);
    int kind, lat_exp, lat_got;
    int phases[$];
    int st_q[$];
    logic rdy_q[$];
    logic z;
    kind = kind_of(o);
    case (kind)
      0: phases = '{0, 1, 2, 3, 4};
      1: phases = '{0, 1, 2, 5};
      2: phases = '{0, 1, 6, 7};
      3: phases = '{0, 1, 8, 7};
      4: phases = '{0, 1, 9, 7};
      5: phases = '{0, 1, 10};
      default: phases = '{0, 1, 11};
    endcase
    foreach (phases[p]) begin
      if (phases[p] == 0 || phases[p] == 3 || phases[p] == 5) begin
        for (int w = 0; w < ((phases[p] == 0) ? fw : mw); w++) begin
          st_q.push_back(phases[p]);
          rdy_q.push_back(1'b0);
        end
        st_q.push_back(phases[p]);
        rdy_q.push_back(1'b1);
      end else begin
        st_q.push_back(phases[p]);
        rdy_q.push_back(1'($urandom_range(0, 1)));
      end
    end
    lat_exp = phases.size() + fw + ((kind <= 1) ? mw : 0);
    lat_got = -1;
    op = o;
    for (int c = 0; c < st_q.size(); c++) begin
      if (st_q[c] == 10) z = bz;
      else if (zmode == 0) z = 1'b0;
      else if (zmode == 1) z = (st_q[c] == 1);
      else z = 1'($urandom_range(0, 1));
      mem_ready = rdy_q[c];
      Zero = z;
      #2;
      check($sformatf("state op=%b cyc=%0d", o, c), 32'(state_dbg), 32'(st_q[c]));
      check($sformatf("outs op=%b st=%0d", o, st_q[c]),
            32'({PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA,
                 ALUSrcB, ALUOp, instr_done, illegal_op}),
            32'(exp_bundle(st_q[c], rdy_q[c], z)));
      check($sformatf("immsrc op=%b", o), 32'(ImmSrc), 32'(exp_imm(o)));
      if (instr_done === 1'b1 && lat_got < 0) lat_got = c + 1;
      @(posedge clk);
      #1;
    end
    check($sformatf("latency op=%b fw=%0d mw=%0d", o, fw, mw), lat_got, lat_exp);
  endtask

  initial begin
    rst_n = 1'b0;
    op = T_R;
    Zero = 1'b1;
    mem_ready = 1'b1;
    #12;
    check("reset state", 32'(state_dbg), 32'd0);
    check("reset outs",
          32'({PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ALUOp, instr_done, illegal_op}),
          32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0}));
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_instr(T_R, 0, 0, 1'b0, 2);
    run_instr(T_LW, 2, 1, 1'b0, 2);
    run_instr(T_SW, 0, 2, 1'b0, 2);
    run_instr(T_BEQ, 0, 0, 1'b1, 0);
    run_instr(T_BEQ, 1, 0, 1'b0, 0);
    run_instr(T_BEQ, 0, 0, 1'b0, 1);
    run_instr(T_JAL, 0, 0, 1'b0, 2);
    run_instr(7'b1110011, 0, 0, 1'b0, 2);
    run_instr(T_I, 1, 0, 1'b0, 2);

    // Reset in the middle of a stalled store.
    op = T_SW;
    mem_ready = 1'b1;
    Zero = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    #1;
    check("midrst pre state", 32'(state_dbg), 32'd5);
    check("midrst pre memwrite", 32'(MemWrite), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst state", 32'(state_dbg), 32'd0);
    check("midrst memwrite", 32'(MemWrite), 32'd0);
    mem_ready = 1'b1;
    #1;
    check("midrst enables", 32'({PCWrite, IRWrite, RegWrite, instr_done}), 32'd0);
    @(posedge clk);
    #1;
    check("midrst held", 32'(state_dbg), 32'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_instr(T_SW, 0, 0, 1'b0, 2);

    for (int n = 0; n < 40; n++) begin
      logic [6:0] o;
      case ($urandom_range(0, 6))
        0: o = T_LW;
        1: o = T_SW;
        2: o = T_R;
        3: o = T_I;
        4: o = T_JAL;
        5: o = T_BEQ;
        default: o = 7'($urandom_range(0, 127));
      endcase
      run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 2);
    end
    #2;
    check("final state", 32'(state_dbg), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
